// File: rtl/qed_inst_gate.sv
// qed_inst_gate: stateful QED instruction-constraint gate.
//   Decodes each issued RV32 word into a class (ILLEGAL/I/LW/R/SW/NOP). It then
//   checks the class against an allow-list that depends on a commit-driven phase
//   (PRE/ARM/POST). Violations are recorded for the surrounding harness.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_instr              instruction word presented at issue
//   i_instr_valid        i_instr is issued this cycle
//   i_sif_commit         SIF commit level from the core
//   i_clr_viol           synchronous clear of violation state
//   o_inst_class         0 ILLEGAL, 1 I, 2 LW, 3 R, 4 SW, 5 NOP (combinational)
//   o_inst_legal         1 if !valid or class allowed in current phase (combinational)
//   o_phase              0 PRE, 1 ARM, 2 POST
//   o_viol_sticky        violation seen since reset/clear
//   o_viol_cnt           saturating violation count
//   o_first_viol_instr   word of the first violation
//   o_sw_cnt             saturating count of legal SWs
module qed_inst_gate #(
  parameter int unsigned REG_SPLIT     = 16,
  parameter int unsigned LW_IMM_LIMIT  = 64,
  parameter int unsigned SW_IMM7_LIMIT = 2,
  parameter int unsigned ENABLE_MUL    = 0,
  parameter int unsigned SW_DELAY      = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_instr,
  input  logic             i_instr_valid,
  input  logic             i_sif_commit,
  input  logic             i_clr_viol,
  output logic [2:0]       o_inst_class,
  output logic             o_inst_legal,
  output logic [1:0]       o_phase,
  output logic             o_viol_sticky,
  output logic [CNT_W-1:0] o_viol_cnt,
  output logic [31:0]      o_first_viol_instr,
  output logic [CNT_W-1:0] o_sw_cnt
);

  localparam logic [2:0] ClsIllegal = 3'd0;
  localparam logic [2:0] ClsI       = 3'd1;
  localparam logic [2:0] ClsLw      = 3'd2;
  localparam logic [2:0] ClsR       = 3'd3;
  localparam logic [2:0] ClsSw      = 3'd4;
  localparam logic [2:0] ClsNop     = 3'd5;

  // Delay counter holds at most SW_DELAY-1.
  localparam int unsigned DLY_W = (SW_DELAY > 1) ? $clog2(SW_DELAY) : 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    PhPre  = 2'd0,
    PhArm  = 2'd1,
    PhPost = 2'd2
  } phase_e;

  phase_e           r_phase;
  logic [DLY_W-1:0] r_dly;
  logic             r_viol_sticky;
  logic [CNT_W-1:0] r_viol_cnt;
  logic [31:0]      r_first_viol;
  logic [CNT_W-1:0] r_sw_cnt;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic [11:0] w_imm12;
  logic        w_rd_ok;
  logic        w_rs1_ok;
  logic        w_rs2_ok;
  logic        w_top_zero;
  logic [2:0]  w_class;
  logic        w_allowed;
  logic        w_viol;
  logic        w_sw_ok;

  assign w_opcode   = i_instr[6:0];
  assign w_rd       = i_instr[11:7];
  assign w_funct3   = i_instr[14:12];
  assign w_rs1      = i_instr[19:15];
  assign w_rs2      = i_instr[24:20];
  assign w_funct7   = i_instr[31:25];
  assign w_imm12    = i_instr[31:20];
  assign w_top_zero = (i_instr[31:30] == 2'b00);

  // Registers must stay in the lower half of the file so the duplicate copy
  // in the upper half is never touched by the original program.
  assign w_rd_ok  = (32'(w_rd)  < REG_SPLIT);
  assign w_rs1_ok = (32'(w_rs1) < REG_SPLIT);
  assign w_rs2_ok = (32'(w_rs2) < REG_SPLIT);

  always_comb begin
    w_class = ClsIllegal;
    case (w_opcode)
      7'b0010011: begin
        if (w_rd_ok && w_rs1_ok) begin
          case (w_funct3)
            3'b001:  if (w_funct7 == 7'b0000000) w_class = ClsI;
            3'b101:  if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) w_class = ClsI;
            default: w_class = ClsI;
          endcase
        end
      end
      7'b0000011: begin
        if (w_funct3 == 3'b010 && w_rs1 == 5'd0 && w_rd_ok && w_top_zero &&
            32'(w_imm12) < LW_IMM_LIMIT) begin
          w_class = ClsLw;
        end
      end
      7'b0110011: begin
        if (w_rd_ok && w_rs1_ok && w_rs2_ok) begin
          if (w_funct7 == 7'b0000000) begin
            w_class = ClsR;
          end else if (w_funct7 == 7'b0100000 &&
                       (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
            w_class = ClsR;
          end else if (ENABLE_MUL != 0 && w_funct7 == 7'b0000001 && !w_funct3[2]) begin
            w_class = ClsR;
          end
        end
      end
      7'b0100011: begin
        if (w_funct3 == 3'b010 && w_rs1 == 5'd0 && w_rs2_ok && w_top_zero &&
            32'(w_funct7) < SW_IMM7_LIMIT) begin
          w_class = ClsSw;
        end
      end
      7'b1111111: w_class = ClsNop;
      default:    w_class = ClsIllegal;
    endcase
  end

  always_comb begin
    w_allowed = 1'b0;
    case (w_class)
      ClsI, ClsLw, ClsR, ClsNop: w_allowed = 1'b1;
      // With no delay the store window opens in the very cycle commit rises,
      // before the registered phase has had a chance to move.
      ClsSw: w_allowed = (r_phase == PhPost) ||
                         (SW_DELAY == 0 && r_phase == PhPre && i_sif_commit);
      default: w_allowed = 1'b0;
    endcase
  end

  assign w_viol  = i_instr_valid && !w_allowed;
  assign w_sw_ok = i_instr_valid && w_allowed && (w_class == ClsSw);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= PhPre;
      r_dly   <= '0;
    end else begin
      case (r_phase)
        PhPre: begin
          if (i_sif_commit) begin
            if (SW_DELAY == 0) begin
              r_phase <= PhPost;
            end else begin
              r_phase <= PhArm;
              r_dly   <= DLY_W'(SW_DELAY - 1);
            end
          end
        end
        PhArm: begin
          if (!i_sif_commit)    r_phase <= PhPre;
          else if (r_dly == '0) r_phase <= PhPost;
          else                  r_dly   <= r_dly - 1'b1;
        end
        PhPost: if (!i_sif_commit) r_phase <= PhPre;
        default: r_phase <= PhPre;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_viol_sticky <= 1'b0;
      r_viol_cnt    <= '0;
      r_first_viol  <= '0;
    end else if (w_viol) begin
      // A violation coinciding with a clear restarts the record from this word.
      r_viol_sticky <= 1'b1;
      if (i_clr_viol)                r_viol_cnt <= CNT_W'(1);
      else if (r_viol_cnt != CntMax) r_viol_cnt <= r_viol_cnt + 1'b1;
      if (i_clr_viol || !r_viol_sticky) r_first_viol <= i_instr;
    end else if (i_clr_viol) begin
      r_viol_sticky <= 1'b0;
      r_viol_cnt    <= '0;
      r_first_viol  <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sw_cnt <= '0;
    end else if (w_sw_ok && r_sw_cnt != CntMax) begin
      r_sw_cnt <= r_sw_cnt + 1'b1;
    end
  end

  assign o_inst_class       = w_class;
  assign o_inst_legal       = !i_instr_valid || w_allowed;
  assign o_phase            = r_phase;
  assign o_viol_sticky      = r_viol_sticky;
  assign o_viol_cnt         = r_viol_cnt;
  assign o_first_viol_instr = r_first_viol;
  assign o_sw_cnt           = r_sw_cnt;

endmodule

// File: tb/tb_qed_inst_gate.sv
// Scoreboard bench for qed_inst_gate. The driver pushes expected values tagged
// with the cycle they must appear in; the monitor compares on each falling edge.
module tb_qed_inst_gate;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        commit = 1'b0;
  logic        clr = 1'b0;

  logic [2:0]  cls, cls_m;
  logic        legal, legal_m;
  logic [1:0]  phase, phase_m;
  logic        sticky, sticky_m;
  logic [7:0]  vcnt, vcnt_m;
  logic [31:0] first, first_m;
  logic [7:0]  swcnt, swcnt_m;

  // Default configuration: SW_DELAY=1, ENABLE_MUL=0.
  qed_inst_gate dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instr_valid(valid),
    .i_sif_commit(commit), .i_clr_viol(clr),
    .o_inst_class(cls), .o_inst_legal(legal), .o_phase(phase),
    .o_viol_sticky(sticky), .o_viol_cnt(vcnt), .o_first_viol_instr(first),
    .o_sw_cnt(swcnt)
  );

  // Alternate configuration: MUL enabled, store legal on commit rise.
  qed_inst_gate #(.ENABLE_MUL(1), .SW_DELAY(0)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instr_valid(valid),
    .i_sif_commit(commit), .i_clr_viol(clr),
    .o_inst_class(cls_m), .o_inst_legal(legal_m), .o_phase(phase_m),
    .o_viol_sticky(sticky_m), .o_viol_cnt(vcnt_m), .o_first_viol_instr(first_m),
    .o_sw_cnt(swcnt_m)
  );

  always #5 clk = ~clk;

  localparam int SelClass = 0, SelLegal = 1, SelPhase = 2, SelSticky = 3;
  localparam int SelCnt = 4, SelFirst = 5, SelSw = 6, SelClassM = 7, SelLegalM = 8;

  localparam logic [31:0] ADDI   = 32'h00510093;
  localparam logic [31:0] SW3    = 32'h00302023;
  localparam logic [31:0] ADD17  = 32'h003108B3;
  localparam logic [31:0] ADD1   = 32'h003100B3;
  localparam logic [31:0] SUB1   = 32'h403100B3;
  localparam logic [31:0] SRAI1  = 32'h40315093;
  localparam logic [31:0] LW64   = 32'h04002083;
  localparam logic [31:0] LW63   = 32'h03F02083;
  localparam logic [31:0] MUL1   = 32'h023100B3;
  localparam logic [31:0] NOP    = 32'h0000007F;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t keep_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int sel);
    case (sel)
      SelClass:  return {29'd0, cls};
      SelLegal:  return {31'd0, legal};
      SelPhase:  return {30'd0, phase};
      SelSticky: return {31'd0, sticky};
      SelCnt:    return {24'd0, vcnt};
      SelFirst:  return first;
      SelSw:     return {24'd0, swcnt};
      SelClassM: return {29'd0, cls_m};
      SelLegalM: return {31'd0, legal_m};
      default:   return 32'hDEADBEEF;
    endcase
  endfunction

  // Monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin
    keep_q = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == cyc) begin
        n_checks++;
        if (sample(sb_q[i].sel) !== sb_q[i].val) begin
          n_errors++;
          $display("FAIL %s @cyc %0d: got 0x%08h want 0x%08h", sb_q[i].name, cyc,
                   sample(sb_q[i].sel), sb_q[i].val);
        end
      end else begin
        keep_q.push_back(sb_q[i]);
      end
    end
    sb_q = keep_q;
  end

  task automatic exp_at(int dc, int sel, logic [31:0] val, string name);
    exp_t e;
    e.cyc = cyc + dc;
    e.sel = sel;
    e.val = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step(logic [31:0] w, logic v, logic c, logic k);
    @(posedge clk);
    #1;
    instr = w;
    valid = v;
    commit = c;
    clr = k;
  endtask

  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    exp_at(0, SelPhase, 0, "rst_phase");
    exp_at(0, SelSticky, 0, "rst_sticky");
    exp_at(0, SelCnt, 0, "rst_cnt");
    exp_at(0, SelFirst, 0, "rst_first");
    exp_at(0, SelSw, 0, "rst_swcnt");

    // Legal ADDI leaves the violation state untouched.
    step(ADDI, 1, 0, 0);
    exp_at(0, SelClass, 1, "addi_class");
    exp_at(0, SelLegal, 1, "addi_legal");
    exp_at(1, SelSticky, 0, "addi_sticky");

    // Store before commit is a violation.
    step(SW3, 1, 0, 0);
    exp_at(0, SelClass, 4, "sw_pre_class");
    exp_at(0, SelLegal, 0, "sw_pre_legal");
    exp_at(0, SelLegalM, 0, "sw_pre_legal_d0");
    exp_at(1, SelSticky, 1, "sw_pre_sticky");
    exp_at(1, SelCnt, 1, "sw_pre_cnt");
    exp_at(1, SelFirst, SW3, "sw_pre_first");
    step(0, 0, 0, 1);
    exp_at(1, SelSticky, 0, "clr_sticky");
    exp_at(1, SelCnt, 0, "clr_cnt");
    exp_at(1, SelFirst, 0, "clr_first");

    // Commit rises at t: ARM at t+1, POST at t+2.
    step(0, 0, 0, 0);
    step(SW3, 1, 1, 0);
    exp_at(0, SelPhase, 0, "t0_phase");
    exp_at(0, SelLegal, 0, "t0_sw_legal");
    exp_at(0, SelLegalM, 1, "t0_sw_legal_d0");
    step(SW3, 1, 1, 0);
    exp_at(0, SelPhase, 1, "t1_phase");
    exp_at(0, SelLegal, 0, "t1_sw_legal");
    step(SW3, 1, 1, 0);
    exp_at(0, SelPhase, 2, "t2_phase");
    exp_at(0, SelLegal, 1, "t2_sw_legal");
    exp_at(0, SelCnt, 2, "t2_cnt");
    exp_at(1, SelSw, 1, "t3_swcnt");
    step(0, 0, 0, 1);
    exp_at(0, SelPhase, 2, "t3_phase");
    exp_at(1, SelPhase, 0, "t4_phase");
    exp_at(1, SelCnt, 0, "t4_cnt");

    // Bound checks and consecutive violations.
    step(ADD17, 1, 0, 0);
    exp_at(0, SelClass, 0, "add17_class");
    exp_at(0, SelLegal, 0, "add17_legal");
    step(LW64, 1, 0, 0);
    exp_at(0, SelClass, 0, "lw64_class");
    exp_at(0, SelLegal, 0, "lw64_legal");
    exp_at(1, SelCnt, 2, "two_viol_cnt");
    exp_at(1, SelFirst, ADD17, "two_viol_first");
    step(MUL1, 1, 0, 1);
    exp_at(0, SelClass, 0, "mul_class");
    exp_at(0, SelLegal, 0, "mul_legal");
    exp_at(0, SelClassM, 3, "mul_class_en");
    exp_at(0, SelLegalM, 1, "mul_legal_en");
    exp_at(1, SelSticky, 1, "clrv_sticky");
    exp_at(1, SelCnt, 1, "clrv_cnt");
    exp_at(1, SelFirst, MUL1, "clrv_first");
    step(ADD1, 1, 0, 0);
    exp_at(0, SelClass, 3, "add_class");
    exp_at(0, SelLegal, 1, "add_legal");
    step(SUB1, 1, 0, 0);
    exp_at(0, SelClass, 3, "sub_class");
    step(SRAI1, 1, 0, 0);
    exp_at(0, SelClass, 1, "srai_class");
    step(LW63, 1, 0, 0);
    exp_at(0, SelClass, 2, "lw63_class");
    exp_at(0, SelLegal, 1, "lw63_legal");
    step(NOP, 1, 0, 0);
    exp_at(0, SelClass, 5, "nop_class");
    exp_at(0, SelLegal, 1, "nop_legal");
    exp_at(1, SelCnt, 1, "legal_cnt_hold");

    // Saturation: 1 + 300 violations clamps at 255.
    for (int i = 0; i < 300; i++) step(32'h0, 1, 0, 0);
    step(0, 0, 0, 0);
    exp_at(0, SelCnt, 255, "sat_cnt");
    exp_at(0, SelFirst, MUL1, "sat_first");

    // Asynchronous reset while in ARM.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #1;
    rst = 1'b1;
    exp_at(0, SelPhase, 0, "arst_phase");
    exp_at(0, SelCnt, 0, "arst_cnt");
    exp_at(0, SelSw, 0, "arst_swcnt");
    exp_at(0, SelSticky, 0, "arst_sticky");
    exp_at(0, SelFirst, 0, "arst_first");
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    exp_at(0, SelPhase, 0, "post_rst_phase");
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
